// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler: round-robin sharing of one SPI DAC driver between two sample sources.
// Define DAC_SCHED_OVERWRITE_EN for latest-value buffering with an overwrite counter (ovr_count).
module dac_update_scheduler #(
    parameter int DATA_W       = 12,
    parameter int MIN_GAP      = 16,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic              CLK_50M,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              dac_busy,
    output logic              dac_start,
    output logic              dac_channel,
    output logic [DATA_W-1:0] dac_data,
    output logic              sched_busy,
    input  logic              err_clear,
    output logic              err_timeout
`ifdef DAC_SCHED_OVERWRITE_EN
    ,
    output logic [15:0]       ovr_count
`endif
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;
    localparam logic [9:0]  GAP_INIT = 10'(MIN_GAP);
    localparam logic [15:0] TO_LAST  = 16'(BUSY_TIMEOUT - 1);

    logic [1:0]        state;
    logic              pend_valid_a, pend_valid_b, last_grant;
    logic [DATA_W-1:0] pend_a, pend_b;
    logic [9:0]        gap;
    logic [15:0]       tcnt;
    logic              grant, grant_a, grant_b, accept_a, accept_b, timeout, done;

`ifdef DAC_SCHED_OVERWRITE_EN
    assign a_ready = 1'b1;
    assign b_ready = 1'b1;
`else
    assign a_ready = ~pend_valid_a;
    assign b_ready = ~pend_valid_b;
`endif

    // On a tie the channel that did not win last time is served.
    always_comb begin
        grant    = (state == IDLE) && (gap == 10'd0) && (pend_valid_a || pend_valid_b);
        grant_b  = pend_valid_b && (!pend_valid_a || !last_grant);
        grant_a  = grant && !grant_b;
        accept_a = a_valid && a_ready;
        accept_b = b_valid && b_ready;
        timeout  = (state == WAIT_BUSY) && !dac_busy && (tcnt == TO_LAST);
        done     = (state == WAIT_DONE) && !dac_busy;
    end

    assign sched_busy = (state != IDLE);

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state        <= IDLE;
            pend_valid_a <= 1'b0;
            pend_valid_b <= 1'b0;
            pend_a       <= '0;
            pend_b       <= '0;
            last_grant   <= 1'b1;
            gap          <= 10'd0;
            tcnt         <= 16'd0;
            dac_start    <= 1'b0;
            dac_channel  <= 1'b0;
            dac_data     <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state <= grant ? LAUNCH :
                     (state == LAUNCH) ? WAIT_BUSY :
                     (state == WAIT_BUSY && dac_busy) ? WAIT_DONE :
                     (timeout || done) ? IDLE : state;
            dac_start <= grant;
            if (grant) begin
                dac_data    <= grant_b ? pend_b : pend_a;
                dac_channel <= grant_b;
                last_grant  <= grant_b;
            end
            // A fresh accept outranks the clear so an overwrite during grant stays pending.
            pend_valid_a <= accept_a || (pend_valid_a && !grant_a);
            pend_valid_b <= accept_b || (pend_valid_b && !(grant && grant_b));
            if (accept_a) pend_a <= a_data;
            if (accept_b) pend_b <= b_data;
            gap  <= (timeout || done) ? GAP_INIT : (gap != 10'd0) ? gap - 10'd1 : gap;
            tcnt <= (state == WAIT_BUSY) ? tcnt + 16'd1 : 16'd0;
            err_timeout <= timeout || (err_timeout && !err_clear);
        end
    end

`ifdef DAC_SCHED_OVERWRITE_EN
    logic        ovr_a, ovr_b;
    logic [1:0]  ovr_inc;
    logic [16:0] ovr_sum;

    always_comb begin
        ovr_a   = a_valid && pend_valid_a && !grant_a;
        ovr_b   = b_valid && pend_valid_b && !(grant && grant_b);
        ovr_inc = {1'b0, ovr_a} + {1'b0, ovr_b};
        ovr_sum = {1'b0, ovr_count} + {15'd0, ovr_inc};
    end

    always_ff @(posedge CLK_50M) begin
        if (reset) ovr_count <= 16'd0;
        else ovr_count <= ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
    end
`endif
endmodule
